// File: rtl/periph_bus_pkg.sv
// Shared types and encodings for the peripheral bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package periph_bus_pkg;

   localparam int WAIT_CYCLES_DEF = 1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // A request is rejected when its size is illegal or its address is not
   // naturally aligned for that size.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/periph_lane_align.sv
// Sub-word lane handling: load extract/extend and store read-modify-write merge.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module periph_lane_align
   import periph_bus_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_unsigned,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_store
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and halfword out of the read word.
   always_comb begin
      w_byte = i_rdata[{i_lane, 3'b000} +: 8];
      w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];
   end

   // Right-align the addressed lane and extend it; words pass through untouched.
   always_comb begin
      o_load = i_rdata;
      case (i_size)
         SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_load = i_rdata;
      endcase
   end

   // Replace only the targeted lane; every other byte is kept exactly as read.
   always_comb begin
      o_store = i_rdata;
      case (i_size)
         SZ_BYTE: o_store[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
         SZ_HALF: o_store[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
         default: o_store = i_wdata;
      endcase
   end

endmodule

// File: rtl/periph_bus_initiator.sv
// CPU-side initiator for the word-wide peripheral bus; sub-word stores via read-modify-write.
// Latency (accept to resp_valid): load W+1, word store 2, sub-word store W+2, error 1.
// Backpressure: one request in flight, req_ready only in IDLE; the response cannot be stalled.
module periph_bus_initiator
   import periph_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int ADDR_W      = 22
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] bus_addr,
   output logic        bus_wr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);

   localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

   // Request captured at accept; the req_* inputs are ignored afterwards.
   logic               r_wr, w_wr_nxt;
   logic [1:0]         r_size, w_size_nxt;
   logic               r_unsigned, w_unsigned_nxt;
   logic [1:0]         r_lane, w_lane_nxt;
   logic [31:0]        r_wdata, w_wdata_nxt;

   logic               r_resp_valid, w_resp_valid_nxt;
   logic [31:0]        r_resp_rdata, w_resp_rdata_nxt;
   logic               r_resp_err, w_resp_err_nxt;
   logic [31:0]        r_bus_addr, w_bus_addr_nxt;
   logic               r_bus_wr, w_bus_wr_nxt;
   logic [31:0]        r_bus_wdata, w_bus_wdata_nxt;

   logic [31:0]        w_load;
   logic [31:0]        w_store;

   periph_lane_align u_align (
      .i_size     (r_size),
      .i_lane     (r_lane),
      .i_unsigned (r_unsigned),
      .i_rdata    (bus_rdata),
      .i_wdata    (r_wdata),
      .o_load     (w_load),
      .o_store    (w_store)
   );

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign bus_addr   = r_bus_addr;
   assign bus_wr     = r_bus_wr;
   assign bus_wdata  = r_bus_wdata;

   // Next state plus next values of every registered output; pulses default low.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_wr_nxt         = r_wr;
      w_size_nxt       = r_size;
      w_unsigned_nxt   = r_unsigned;
      w_lane_nxt       = r_lane;
      w_wdata_nxt      = r_wdata;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = 32'd0;
      w_resp_err_nxt   = 1'b0;
      w_bus_addr_nxt   = r_bus_addr;
      w_bus_wr_nxt     = 1'b0;
      w_bus_wdata_nxt  = r_bus_wdata;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_wr_nxt       = req_wr;
               w_size_nxt     = req_size;
               w_unsigned_nxt = req_unsigned;
               w_lane_nxt     = req_addr[1:0];
               w_wdata_nxt    = req_wdata;
               if (req_bad(req_size, req_addr[1:0])) begin
                  // Rejected requests never touch the bus.
                  w_state_nxt      = ST_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_err_nxt   = 1'b1;
               end else begin
                  w_bus_addr_nxt = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                  if (!req_wr || req_size != SZ_WORD) begin
                     w_state_nxt = ST_READ;
                     w_cnt_nxt   = CNT_W'(WAIT_CYCLES);
                  end else begin
                     w_state_nxt     = ST_WRITE;
                     w_bus_wr_nxt    = 1'b1;
                     w_bus_wdata_nxt = req_wdata;
                  end
               end
            end
         end
         ST_READ: begin
            if (r_cnt == CNT_W'(1)) begin
               if (!r_wr) begin
                  w_state_nxt      = ST_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_rdata_nxt = w_load;
               end else begin
                  w_state_nxt     = ST_WRITE;
                  w_bus_wr_nxt    = 1'b1;
                  w_bus_wdata_nxt = w_store;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_WRITE: begin
            w_state_nxt      = ST_RESP;
            w_resp_valid_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Counter, request latch and output registers; reset clears any in-flight request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_wr         <= 1'b0;
         r_size       <= SZ_BYTE;
         r_unsigned   <= 1'b0;
         r_lane       <= 2'd0;
         r_wdata      <= 32'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
         r_bus_addr   <= 32'd0;
         r_bus_wr     <= 1'b0;
         r_bus_wdata  <= 32'd0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_wr         <= w_wr_nxt;
         r_size       <= w_size_nxt;
         r_unsigned   <= w_unsigned_nxt;
         r_lane       <= w_lane_nxt;
         r_wdata      <= w_wdata_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
         r_bus_addr   <= w_bus_addr_nxt;
         r_bus_wr     <= w_bus_wr_nxt;
         r_bus_wdata  <= w_bus_wdata_nxt;
      end
   end

endmodule
